// File: rtl/spike_timestamp_fifo.sv
// Spike event timestamper: rising-edge detect on spike_in, prescaled free-running
// timebase, FWFT FIFO of event timestamps, saturating drop counter.
module spike_timestamp_fifo #(
    parameter int TS_WIDTH   = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int PRESCALE   = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spike_in,
    input  logic                  clear,
    input  logic                  ev_ready,
    output logic                  ev_valid,
    output logic [TS_WIDTH-1:0]   ev_timestamp,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [7:0]            overflow_cnt
);

    // Keep the prescale counter at least one bit wide so PRESCALE=1 still elaborates.
    localparam int                  PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]       PCNT_MAX   = PW'(PRESCALE - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic                  spike_prev_q, spike_prev_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [7:0]            ovf_q, ovf_d;

    logic [TS_WIDTH-1:0]   mem [DEPTH];
    logic                  spike_event, push, pop, wr_en;

    assign ev_valid     = (count_q != '0);
    assign empty        = (count_q == '0);
    assign full         = (count_q == COUNT_FULL);
    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign ev_timestamp = mem[rd_ptr_q];

    always_comb begin
        pcnt_d       = pcnt_q;
        ts_d         = ts_q;
        spike_prev_d = spike_in;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        wr_en        = 1'b0;

        spike_event = spike_in & ~spike_prev_q;
        pop         = ev_valid & ev_ready;
        // A full FIFO can still accept when the head leaves on the same edge.
        push        = spike_event & (~full | pop);

        if (clear) begin
            pcnt_d   = '0;
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = '0;
        end else begin
            if (pcnt_q == PCNT_MAX) begin
                pcnt_d = '0;
                ts_d   = ts_q + 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end

            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (spike_event && !push && (ovf_q != 8'hFF)) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q       <= '0;
            ts_q         <= '0;
            spike_prev_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= '0;
        end else begin
            pcnt_q       <= pcnt_d;
            ts_q         <= ts_d;
            spike_prev_q <= spike_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage carries no reset; stale slots are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= ts_q;
        end
    end

endmodule

// File: tb/tb_spike_timestamp_fifo.sv
// Directed bench for spike_timestamp_fifo: instance a (TS 16b, PRESCALE 4, DEPTH 8)
// and instance b (TS 4b, PRESCALE 1) for the timestamp wrap case.
module tb_spike_timestamp_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spike_a = 1'b0, clear_a = 1'b0, ready_a = 1'b0;
    logic       spike_b = 1'b0, clear_b = 1'b0, ready_b = 1'b0;
    logic       valid_a, full_a, empty_a;
    logic       valid_b, full_b, empty_b;
    logic [15:0] ts_a;
    logic [3:0]  ts_b, count_a, count_b;
    logic [7:0]  ovf_a, ovf_b;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    spike_timestamp_fifo #(.TS_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .PRESCALE(4)) dut_a (
        .clk(clk), .reset(reset), .spike_in(spike_a), .clear(clear_a), .ev_ready(ready_a),
        .ev_valid(valid_a), .ev_timestamp(ts_a), .count(count_a), .full(full_a),
        .empty(empty_a), .overflow_cnt(ovf_a)
    );

    spike_timestamp_fifo #(.TS_WIDTH(4), .DEPTH(8), .ADDR_WIDTH(3), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(reset), .spike_in(spike_b), .clear(clear_b), .ev_ready(ready_b),
        .ev_valid(valid_b), .ev_timestamp(ts_b), .count(count_b), .full(full_b),
        .empty(empty_b), .overflow_cnt(ovf_b)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // Release lands between edges, so the next rising edge is edge 1.
    task automatic do_reset();
        spike_a = 0; clear_a = 0; ready_a = 0;
        spike_b = 0; clear_b = 0; ready_b = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic pulse_a();
        spike_a = 1'b1; step();
        spike_a = 1'b0; step();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty_a); end
        tests++; if (full_a !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full_a); end
        tests++; if (count_a !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_a); end
        tests++; if (ovf_a !== 8'd0) begin fails++; $display("FAIL reset_ovf: got %0d expected 0", ovf_a); end
        tests++; if (valid_b !== 1'b0) begin fails++; $display("FAIL reset_valid_b: got %b expected 0", valid_b); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_first_event();
        do_reset();
        while (edge_cnt < 10) step();
        spike_a = 1'b1; step();   // edge 11 samples the spike
        spike_a = 1'b0;
        tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL first_valid: got %b expected 1", valid_a); end
        tests++; if (ts_a !== 16'd2) begin fails++; $display("FAIL first_ts: got %0d expected 2", ts_a); end
        tests++; if (count_a !== 4'd1) begin fails++; $display("FAIL first_count: got %0d expected 1", count_a); end
        $display("[TB] test_first_event done");
    endtask

    task automatic test_level();
        do_reset();
        spike_a = 1'b1;           // high from reset release: event on edge 1
        repeat (20) step();
        spike_a = 1'b0;
        repeat (3) step();
        tests++; if (count_a !== 4'd1) begin fails++; $display("FAIL level_count: got %0d expected 1", count_a); end
        tests++; if (ovf_a !== 8'd0) begin fails++; $display("FAIL level_ovf: got %0d expected 0", ovf_a); end
        tests++; if (ts_a !== 16'd0) begin fails++; $display("FAIL level_ts: got %0d expected 0", ts_a); end
        $display("[TB] test_level done");
    endtask

    task automatic test_overflow();
        // Events sampled at edges 1,4,...,28; first eight stored with floor((e-1)/4).
        int exp_ts[8] = '{0, 0, 1, 2, 3, 3, 4, 5};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            spike_a = 1'b1; step();
            spike_a = 1'b0; step(); step();
        end
        tests++; if (count_a !== 4'd8) begin fails++; $display("FAIL ovf_count: got %0d expected 8", count_a); end
        tests++; if (full_a !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b expected 1", full_a); end
        tests++; if (ovf_a !== 8'd2) begin fails++; $display("FAIL ovf_cnt: got %0d expected 2", ovf_a); end
        ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL ovf_pop_valid[%0d]: got %b expected 1", i, valid_a); end
            tests++; if (ts_a !== 16'(exp_ts[i])) begin fails++; $display("FAIL ovf_pop_ts[%0d]: got %0d expected %0d", i, ts_a, exp_ts[i]); end
            step();
        end
        ready_a = 1'b0;
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL ovf_drain_empty: got %b expected 1", empty_a); end
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL ovf_drain_valid: got %b expected 0", valid_a); end
        tests++; if (ovf_a !== 8'd2) begin fails++; $display("FAIL ovf_cnt_hold: got %0d expected 2", ovf_a); end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_full_push_pop();
        // Fill at edges 1,3,...,15 (ts 0,0,1,1,2,2,3,3); push+pop at edge 17 stores ts 4.
        int exp_ts[8] = '{0, 1, 1, 2, 2, 3, 3, 4};
        do_reset();
        for (int k = 0; k < 8; k++) pulse_a();
        tests++; if (full_a !== 1'b1) begin fails++; $display("FAIL fpp_full_pre: got %b expected 1", full_a); end
        spike_a = 1'b1; ready_a = 1'b1; step();
        spike_a = 1'b0; ready_a = 1'b0;
        tests++; if (count_a !== 4'd8) begin fails++; $display("FAIL fpp_count: got %0d expected 8", count_a); end
        tests++; if (ovf_a !== 8'd0) begin fails++; $display("FAIL fpp_ovf: got %0d expected 0", ovf_a); end
        ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++; if (ts_a !== 16'(exp_ts[i]) || valid_a !== 1'b1) begin
                fails++; $display("FAIL fpp_pop[%0d]: got ts %0d valid %b expected ts %0d valid 1", i, ts_a, valid_a, exp_ts[i]);
            end
            step();
        end
        ready_a = 1'b0;
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL fpp_empty: got %b expected 1", empty_a); end
        $display("[TB] test_full_push_pop done");
    endtask

    task automatic test_ts_wrap();
        do_reset();
        while (edge_cnt < 2) step();
        spike_b = 1'b1; step();   // edge 3 -> ts 2
        spike_b = 1'b0;
        while (edge_cnt < 19) step();
        spike_b = 1'b1; step();   // edge 20 -> 19 mod 16 = 3
        spike_b = 1'b0;
        tests++; if (count_b !== 4'd2) begin fails++; $display("FAIL wrap_count: got %0d expected 2", count_b); end
        tests++; if (ts_b !== 4'd2) begin fails++; $display("FAIL wrap_ts0: got %0d expected 2", ts_b); end
        ready_b = 1'b1; step(); ready_b = 1'b0;
        tests++; if (ts_b !== 4'd3) begin fails++; $display("FAIL wrap_ts1: got %0d expected 3", ts_b); end
        tests++; if (count_b !== 4'd1) begin fails++; $display("FAIL wrap_count1: got %0d expected 1", count_b); end
        ready_b = 1'b1; step(); ready_b = 1'b0;
        tests++; if (valid_b !== 1'b0) begin fails++; $display("FAIL wrap_valid_end: got %b expected 0", valid_b); end
        $display("[TB] test_ts_wrap done");
    endtask

    task automatic test_clear();
        do_reset();
        for (int k = 0; k < 13; k++) pulse_a();   // 8 stored, 5 dropped
        ready_a = 1'b1; repeat (5) step(); ready_a = 1'b0;
        tests++; if (count_a !== 4'd3) begin fails++; $display("FAIL clr_pre_count: got %0d expected 3", count_a); end
        tests++; if (ovf_a !== 8'd5) begin fails++; $display("FAIL clr_pre_ovf: got %0d expected 5", ovf_a); end
        clear_a = 1'b1; spike_a = 1'b1; step();
        clear_a = 1'b0; spike_a = 1'b0;
        tests++; if (count_a !== 4'd0) begin fails++; $display("FAIL clr_count: got %0d expected 0", count_a); end
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL clr_empty: got %b expected 1", empty_a); end
        tests++; if (ovf_a !== 8'd0) begin fails++; $display("FAIL clr_ovf: got %0d expected 0", ovf_a); end
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL clr_valid: got %b expected 0", valid_a); end
        // Timebase restarts at the clear edge; an event 6 edges later sees ts = floor(5/4) = 1.
        repeat (5) step();
        spike_a = 1'b1; step(); spike_a = 1'b0;
        tests++; if (ts_a !== 16'd1) begin fails++; $display("FAIL clr_restart_ts: got %0d expected 1", ts_a); end
        tests++; if (count_a !== 4'd1) begin fails++; $display("FAIL clr_restart_count: got %0d expected 1", count_a); end
        $display("[TB] test_clear done");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) pulse_a();
        tests++; if (count_a !== 4'd3) begin fails++; $display("FAIL ar_pre_count: got %0d expected 3", count_a); end
        reset = 1'b1;
        #2;   // no clock edge in between
        tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b expected 0", valid_a); end
        tests++; if (count_a !== 4'd0) begin fails++; $display("FAIL ar_count: got %0d expected 0", count_a); end
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL ar_empty: got %b expected 1", empty_a); end
        tests++; if (full_a !== 1'b0) begin fails++; $display("FAIL ar_full: got %b expected 0", full_a); end
        tests++; if (ovf_a !== 8'd0) begin fails++; $display("FAIL ar_ovf: got %0d expected 0", ovf_a); end
        do_reset();
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_level();
        test_overflow();
        test_full_push_pop();
        test_ts_wrap();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spike_timestamp_fifo.md
Name: spike_timestamp_fifo

Overview:
- Downstream consumer of the LIF neuron's `spike_out` pulse.
- Detects each spike event and tags it with a free-running prescaled timestamp.
- Buffers events in a small FIFO, presented on a first-word-fall-through valid/ready read port for a logger or host-interface stage.
- Counts events dropped while the FIFO is full.

Parameters:
- TS_WIDTH, 16, width of the timestamp counter and of stored entries.
- DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH).
- PRESCALE, 100, clk cycles per timestamp tick (1 us at 100 MHz); minimum 1.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-high reset.
- spike_in  input  1  spike from neuron; level or pulse, rising edge = event.
- clear  input  1  synchronous flush of FIFO, timestamp and drop counter.
- ev_ready  input  1  consumer accepts head entry.
- ev_valid  output  1  FIFO non-empty; head entry valid.
- ev_timestamp  output  TS_WIDTH  timestamp of head entry.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow_cnt  output  8  dropped events, saturating at 255.

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous, active-high.
- Reset values: prescale counter 0, ts 0, spike_prev 0, pointers 0, count 0, overflow_cnt 0.
  - Outputs after reset: ev_valid 0, empty 1, full 0.
  - ev_timestamp is don't-care while ev_valid is 0.
- Timebase:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - ts increments on every edge where pcnt == PRESCALE-1.
  - ts wraps modulo 2^TS_WIDTH without any flag.
  - After edge n from reset, ts = floor(n/PRESCALE) mod 2^TS_WIDTH.
- Event detect:
  - spike_prev <= spike_in every cycle, including during clear.
  - event = spike_in & ~spike_prev.
  - A level held high gives exactly one event.
  - spike_in high at reset release gives one event on the first edge.
- Push:
  - On an event edge, the pre-update ts value is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - Accepted if not full, or if full and a pop occurs in the same cycle.
- Pop: pop = ev_valid & ev_ready; rd_ptr increments modulo DEPTH.
- Read port is FWFT:
  - ev_timestamp = mem[rd_ptr].
  - ev_valid = ~empty, registered and driven from the count register.
- Latency: an event sampled at edge k is visible with ev_valid = 1 after edge k. There is no bypass path.
  - Push into an empty FIFO while ev_ready = 1 does not pop that cycle.
- Count update: count +1 on push only, -1 on pop only, unchanged on both or neither.
- Overflow:
  - Event while full and no pop: entry dropped, FIFO contents untouched.
  - overflow_cnt increments unless already 255.
- clear:
  - Highest priority below reset. On that edge: pointers, count, overflow_cnt, ts and pcnt go to 0.
  - Any push or pop in the same cycle is ignored.
- Entries leave in arrival order; stored timestamps are non-decreasing modulo wrap.
- Async reset mid-operation discards all entries immediately. No partial state survives.

Test Plan:
- PRESCALE=4, ev_ready=0; spike_in pulses first sampled high at edge 11 after reset -> ev_valid=1 after edge 11, ev_timestamp=2, count=1.
- spike_in held high 20 cycles, then low -> exactly one entry, count=1, overflow_cnt=0.
- DEPTH=8, ev_ready=0; 10 one-cycle pulses spaced 3 cycles apart -> count=8, full=1, overflow_cnt=2. Then ev_ready=1 -> 8 pops in order with non-decreasing timestamps, then empty=1, ev_valid=0.
- FIFO full; event and pop in the same cycle -> count stays 8, overflow_cnt unchanged, new timestamp is the last entry drained.
- TS_WIDTH=4, PRESCALE=1; events sampled at edges 3 and 20 -> timestamps 2 and 3 (19 mod 16).
- 3 entries plus overflow_cnt=5, then clear asserted for one cycle with a coincident event -> next cycle count=0, empty=1, overflow_cnt=0, next event timestamp restarts from 0. Repeat with async reset asserted mid-cycle -> outputs at reset values immediately.
